bip_acc_tx_ctrl: RTL



---
 rtl/bip_acc_tx_ctrl_pkg.sv | 23 ++
 rtl/bip_acc_byte_sel.sv | 30 +++
 rtl/bip_acc_tx_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/bip_acc_tx_ctrl_pkg.sv
// bip_acc_tx_ctrl_pkg: shared state encodings, sizing helpers and default header
// for the BIP accumulator transmit sequencer.
package bip_acc_tx_ctrl_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/bip_acc_byte_sel.sv
// bip_acc_byte_sel: picks the header byte or a zero-padded accumulator byte
// for transmit frame idx.
module bip_acc_byte_sel
    import bip_acc_tx_ctrl_pkg::*;
#(
    parameter int NBITS_D = 16,
    parameter int DBIT = 8,
    parameter int HEADER_EN = 1,
    parameter logic [DBIT-1:0] HEADER = DBIT'(DEFAULT_HEADER),
    parameter int IW = 2
) (
    input  logic [NBITS_D-1:0] acc,
    input  logic [IW-1:0]      idx,
    output logic [DBIT-1:0]    frame
);

    localparam int NBYTES = ceil_div(NBITS_D, DBIT);
    localparam int PW = NBYTES * DBIT;

    logic [PW-1:0] padded;
    logic [IW-1:0] bi;
    logic          is_header;

    assign padded    = PW'(acc);
    assign is_header = (HEADER_EN != 0) && (idx == '0);
    // with a header, frame 0 is the header so accumulator bytes start at frame 1
    assign bi        = (HEADER_EN != 0) ? idx - IW'(1) : idx;
    assign frame     = is_header ? HEADER : padded[bi*DBIT +: DBIT];

endmodule

// File: rtl/bip_acc_tx_ctrl.sv
// bip_acc_tx_ctrl: on a BIP halt rising edge, latches the accumulator and feeds
// an optional header plus the accumulator bytes (LSB first) to uart_tx.
module bip_acc_tx_ctrl
    import bip_acc_tx_ctrl_pkg::*;
#(
    parameter int NBITS_D = 16,
    parameter int DBIT = 8,
    parameter int HEADER_EN = 1,
    parameter logic [DBIT-1:0] HEADER = DBIT'(DEFAULT_HEADER)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic [NBITS_D-1:0] i_acc,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [DBIT-1:0]    o_tx_data,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NBYTES = ceil_div(NBITS_D, DBIT);
    localparam int NFRAMES = NBYTES + HEADER_EN;
    localparam int IW = (clog2(NFRAMES) < 1) ? 1 : clog2(NFRAMES);
    localparam logic [IW-1:0] LAST = IW'(NFRAMES - 1);

    logic [1:0]         state;
    logic               halt_q;
    logic               trig;
    logic [NBITS_D-1:0] acc_lat;
    logic [IW-1:0]      idx;
    logic [DBIT-1:0]    frame;

    assign trig = i_halt & ~halt_q;

    bip_acc_byte_sel #(
        .NBITS_D  (NBITS_D),
        .DBIT     (DBIT),
        .HEADER_EN(HEADER_EN),
        .HEADER   (HEADER),
        .IW       (IW)
    ) u_byte_sel (
        .acc  (acc_lat),
        .idx  (idx),
        .frame(frame)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            halt_q     <= 1'b0;
            acc_lat    <= '0;
            idx        <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            halt_q     <= i_halt;
            o_tx_start <= 1'b0;
            case (state)
                IDLE: if (trig) begin
                    acc_lat <= i_acc;
                    idx     <= '0;
                    o_busy  <= 1'b1;
                    state   <= LOAD;
                end
                LOAD: begin
                    o_tx_data  <= frame;
                    o_tx_start <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: if (i_tx_done) begin
                    if (idx == LAST) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= LOAD;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
